// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter for a single-port synchronous byte memory,
// with an owner lock for atomic sequences and an idle-owner lock timeout.
module mem_arbiter #(
    parameter int unsigned ADDR_W   = 8,
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned LOCK_MAX = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_req,
    input  logic              a_we,
    input  logic              a_lock,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_gnt,
    output logic              a_rvalid,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic              b_lock,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_gnt,
    output logic              b_rvalid,
    output logic [DATA_W-1:0] b_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              lock_timeout
);

    localparam int unsigned CNT_W = (LOCK_MAX > 0) ? $clog2(LOCK_MAX + 1) : 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOCK_A = 2'd1,
        ST_LOCK_B = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic               last_b_q, last_b_d;
    logic [CNT_W-1:0]   idle_cnt_q, idle_cnt_d;
    logic               a_rvalid_q, a_rvalid_d;
    logic               b_rvalid_q, b_rvalid_d;
    logic               lock_timeout_q, lock_timeout_d;
    logic               idle_hit;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            last_b_q       <= 1'b1;
            idle_cnt_q     <= '0;
            a_rvalid_q     <= 1'b0;
            b_rvalid_q     <= 1'b0;
            lock_timeout_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            last_b_q       <= last_b_d;
            idle_cnt_q     <= idle_cnt_d;
            a_rvalid_q     <= a_rvalid_d;
            b_rvalid_q     <= b_rvalid_d;
            lock_timeout_q <= lock_timeout_d;
        end
    end

    // The lock owner has now been idle for LOCK_MAX consecutive cycles
    assign idle_hit = (LOCK_MAX != 0) && (idle_cnt_q == CNT_W'(LOCK_MAX - 1));

    // Next-state logic
    always_comb begin
        state_d        = state_q;
        last_b_d       = last_b_q;
        idle_cnt_d     = idle_cnt_q;
        a_rvalid_d     = a_gnt && !a_we;
        b_rvalid_d     = b_gnt && !b_we;
        lock_timeout_d = 1'b0;

        if (a_gnt) begin
            last_b_d = 1'b0;
        end else if (b_gnt) begin
            last_b_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                idle_cnt_d = '0;
                if (a_gnt && a_lock) begin
                    state_d = ST_LOCK_A;
                end else if (b_gnt && b_lock) begin
                    state_d = ST_LOCK_B;
                end
            end
            ST_LOCK_A: begin
                if (a_gnt) begin
                    idle_cnt_d = '0;
                    if (!a_lock) begin
                        state_d = ST_IDLE;
                    end
                end else if (idle_hit) begin
                    state_d        = ST_IDLE;
                    idle_cnt_d     = '0;
                    lock_timeout_d = 1'b1;
                end else if (LOCK_MAX != 0) begin
                    idle_cnt_d = idle_cnt_q + CNT_W'(1);
                end
            end
            ST_LOCK_B: begin
                if (b_gnt) begin
                    idle_cnt_d = '0;
                    if (!b_lock) begin
                        state_d = ST_IDLE;
                    end
                end else if (idle_hit) begin
                    state_d        = ST_IDLE;
                    idle_cnt_d     = '0;
                    lock_timeout_d = 1'b1;
                end else if (LOCK_MAX != 0) begin
                    idle_cnt_d = idle_cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d    = ST_IDLE;
                idle_cnt_d = '0;
            end
        endcase
    end

    // Grant decision and memory-side mux; grants land on mem_* in the request cycle
    always_comb begin
        a_gnt     = 1'b0;
        b_gnt     = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;

        if (!rst) begin
            case (state_q)
                ST_IDLE: begin
                    if (a_req && b_req) begin
                        a_gnt = last_b_q;
                        b_gnt = !last_b_q;
                    end else begin
                        a_gnt = a_req;
                        b_gnt = b_req;
                    end
                end
                ST_LOCK_A: a_gnt = a_req;
                ST_LOCK_B: b_gnt = b_req;
                default: ;
            endcase
        end

        mem_en = a_gnt | b_gnt;
        if (a_gnt) begin
            mem_we    = a_we;
            mem_addr  = a_addr;
            mem_wdata = a_wdata;
        end else if (b_gnt) begin
            mem_we    = b_we;
            mem_addr  = b_addr;
            mem_wdata = b_wdata;
        end
    end

    assign a_rvalid     = a_rvalid_q;
    assign b_rvalid     = b_rvalid_q;
    assign a_rdata      = mem_rdata;
    assign b_rdata      = mem_rdata;
    assign lock_timeout = lock_timeout_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus a randomized
// run scored against a transaction-level arbitration/memory model.
module tb_mem_arbiter;

    localparam int unsigned AW       = 8;
    localparam int unsigned DW       = 8;
    localparam int          LOCK_MAX = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          a_req, a_we, a_lock, a_gnt, a_rvalid;
    logic [AW-1:0] a_addr;
    logic [DW-1:0] a_wdata, a_rdata;
    logic          b_req, b_we, b_lock, b_gnt, b_rvalid;
    logic [AW-1:0] b_addr;
    logic [DW-1:0] b_wdata, b_rdata;
    logic          mem_en, mem_we, lock_timeout;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;

    logic          n_a_req, n_a_lock, n_a_gnt, n_a_rvalid;
    logic          n_b_req, n_b_gnt, n_b_rvalid;
    logic [DW-1:0] n_a_rdata, n_b_rdata, n_mem_wdata;
    logic [AW-1:0] n_mem_addr;
    logic          n_mem_en, n_mem_we, n_lock_timeout;

    int n_checks = 0;
    int n_fail   = 0;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LOCK_MAX(LOCK_MAX)) dut (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_we(a_we), .a_lock(a_lock), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_lock(b_lock), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .lock_timeout(lock_timeout)
    );

    // Second instance with the timeout disabled
    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LOCK_MAX(0)) dut_nt (
        .clk(clk), .rst(rst),
        .a_req(n_a_req), .a_we(1'b0), .a_lock(n_a_lock), .a_addr(8'hF0), .a_wdata(8'h00),
        .a_gnt(n_a_gnt), .a_rvalid(n_a_rvalid), .a_rdata(n_a_rdata),
        .b_req(n_b_req), .b_we(1'b0), .b_lock(1'b0), .b_addr(8'h22), .b_wdata(8'h00),
        .b_gnt(n_b_gnt), .b_rvalid(n_b_rvalid), .b_rdata(n_b_rdata),
        .mem_en(n_mem_en), .mem_we(n_mem_we), .mem_addr(n_mem_addr), .mem_wdata(n_mem_wdata),
        .mem_rdata(8'h00), .lock_timeout(n_lock_timeout)
    );

    function automatic logic [DW-1:0] init_val(input int i);
        return (i == 'hF0) ? 8'h10 : 8'((i * 7) + 3);
    endfunction

    // Behavioural single-port memory with 1-cycle read latency
    logic [DW-1:0] mem [256];
    logic [DW-1:0] mem_rdata_q;
    logic          mem_load;
    always @(posedge clk) begin
        if (mem_load) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
        end else if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mem_rdata_q   <= mem[mem_addr];
        end
    end
    assign mem_rdata = mem_rdata_q;

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic drv_a(input logic req, we, lock, input logic [AW-1:0] addr, input logic [DW-1:0] wd);
        a_req = req; a_we = we; a_lock = lock; a_addr = addr; a_wdata = wd;
    endtask

    task automatic drv_b(input logic req, we, lock, input logic [AW-1:0] addr, input logic [DW-1:0] wd);
        b_req = req; b_we = we; b_lock = lock; b_addr = addr; b_wdata = wd;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drv_a(0, 0, 0, 0, 0);
        drv_b(0, 0, 0, 0, 0);
        nxt();
        nxt();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        mem_load = 1'b1;
        n_a_req = 0; n_a_lock = 0; n_b_req = 0;
        drv_a(1, 0, 0, 8'hF0, 0);
        drv_b(1, 1, 0, 8'h10, 8'h55);
        #1;
        n_checks++;
        if ({a_gnt, b_gnt, mem_en, mem_we} !== 4'b0000)
            begin n_fail++; $display("FAIL reset_gnt got=%b exp=0000", {a_gnt, b_gnt, mem_en, mem_we}); end
        nxt();
        nxt();
        n_checks++;
        if ({a_rvalid, b_rvalid, lock_timeout} !== 3'b000)
            begin n_fail++; $display("FAIL reset_regs got=%b exp=000", {a_rvalid, b_rvalid, lock_timeout}); end
        n_checks++;
        if ({mem_addr, mem_wdata} !== 16'h0)
            begin n_fail++; $display("FAIL reset_membus got=%h exp=0000", {mem_addr, mem_wdata}); end
        mem_load = 1'b0;
        drv_a(0, 0, 0, 0, 0);
        drv_b(0, 0, 0, 0, 0);
        rst = 1'b0;
    endtask

    task automatic test_single_read();
        drv_a(1, 0, 0, 8'hF0, 0);
        #1;
        n_checks++;
        if ({a_gnt, b_gnt, mem_en, mem_we, mem_addr} !== {4'b1010, 8'hF0})
            begin n_fail++; $display("FAIL single_grant got=%h exp=%h", {a_gnt, b_gnt, mem_en, mem_we, mem_addr}, {4'b1010, 8'hF0}); end
        nxt();
        drv_a(0, 0, 0, 0, 0);
        #1;
        n_checks++;
        if ({a_rvalid, b_rvalid, a_rdata} !== {2'b10, 8'h10})
            begin n_fail++; $display("FAIL single_rdata got=%h exp=%h", {a_rvalid, b_rvalid, a_rdata}, {2'b10, 8'h10}); end
        nxt();
    endtask

    task automatic test_round_robin();
        logic ea;
        do_reset();
        drv_a(1, 0, 0, 8'hF0, 0);
        drv_b(1, 0, 0, 8'h20, 0);
        for (int i = 0; i < 10; i++) begin
            #1;
            ea = (i % 2 == 0);
            n_checks++;
            if ({a_gnt, b_gnt, mem_addr} !== {ea, !ea, ea ? 8'hF0 : 8'h20})
                begin n_fail++; $display("FAIL rr_grant[%0d] got=%h exp=%h", i, {a_gnt, b_gnt, mem_addr}, {ea, !ea, ea ? 8'hF0 : 8'h20}); end
            if (i > 0) begin
                n_checks++;
                if ({a_rvalid, b_rvalid, mem_rdata} !== {!ea, ea, ea ? init_val('h20) : 8'h10})
                    begin n_fail++; $display("FAIL rr_rvalid[%0d] got=%h exp=%h", i, {a_rvalid, b_rvalid, mem_rdata}, {!ea, ea, ea ? init_val('h20) : 8'h10}); end
            end
            nxt();
        end
        drv_a(0, 0, 0, 0, 0);
        drv_b(0, 0, 0, 0, 0);
        #1;
        n_checks++;
        if ({a_rvalid, b_rvalid, b_rdata} !== {2'b01, init_val('h20)})
            begin n_fail++; $display("FAIL rr_last got=%h exp=%h", {a_rvalid, b_rvalid, b_rdata}, {2'b01, init_val('h20)}); end
        nxt();
    endtask

    task automatic test_lock_atomic();
        do_reset();
        drv_b(1, 0, 0, 8'h30, 0);
        drv_a(1, 0, 1, 8'hF0, 0);
        #1;
        n_checks++;
        if ({a_gnt, b_gnt, mem_we} !== 3'b100)
            begin n_fail++; $display("FAIL lock_c0 got=%b exp=100", {a_gnt, b_gnt, mem_we}); end
        nxt();
        drv_a(1, 0, 1, 8'hF1, 0);
        #1;
        n_checks++;
        if ({a_gnt, b_gnt, a_rvalid, a_rdata} !== {3'b101, 8'h10})
            begin n_fail++; $display("FAIL lock_c1 got=%h exp=%h", {a_gnt, b_gnt, a_rvalid, a_rdata}, {3'b101, 8'h10}); end
        nxt();
        drv_a(1, 1, 0, 8'hF0, 8'h0F);
        #1;
        n_checks++;
        if ({a_gnt, b_gnt, mem_we, mem_wdata} !== {3'b101, 8'h0F})
            begin n_fail++; $display("FAIL lock_c2 got=%h exp=%h", {a_gnt, b_gnt, mem_we, mem_wdata}, {3'b101, 8'h0F}); end
        n_checks++;
        if ({a_rvalid, a_rdata} !== {1'b1, init_val('hF1)})
            begin n_fail++; $display("FAIL lock_c2_rdata got=%h exp=%h", {a_rvalid, a_rdata}, {1'b1, init_val('hF1)}); end
        nxt();
        drv_a(0, 0, 0, 0, 0);
        #1;
        n_checks++;
        if ({a_gnt, b_gnt, a_rvalid, mem_addr} !== {3'b010, 8'h30})
            begin n_fail++; $display("FAIL lock_release got=%h exp=%h", {a_gnt, b_gnt, a_rvalid, mem_addr}, {3'b010, 8'h30}); end
        nxt();
        drv_b(0, 0, 0, 0, 0);
        drv_a(1, 0, 0, 8'hF0, 0);
        #1;
        n_checks++;
        if ({a_gnt, b_rvalid, b_rdata} !== {2'b11, init_val('h30)})
            begin n_fail++; $display("FAIL lock_c4 got=%h exp=%h", {a_gnt, b_rvalid, b_rdata}, {2'b11, init_val('h30)}); end
        nxt();
        drv_a(0, 0, 0, 0, 0);
        #1;
        n_checks++;
        if ({a_rvalid, a_rdata} !== {1'b1, 8'h0F})
            begin n_fail++; $display("FAIL lock_readback got=%h exp=%h", {a_rvalid, a_rdata}, {1'b1, 8'h0F}); end
        nxt();
    endtask

    task automatic test_timeout();
        do_reset();
        drv_b(1, 0, 0, 8'h40, 0);
        drv_a(1, 0, 1, 8'hF1, 0);
        #1;
        n_checks++;
        if ({a_gnt, b_gnt} !== 2'b10)
            begin n_fail++; $display("FAIL to_lockgrant got=%b exp=10", {a_gnt, b_gnt}); end
        nxt();
        drv_a(0, 0, 0, 0, 0);
        for (int i = 1; i <= LOCK_MAX; i++) begin
            #1;
            n_checks++;
            if ({b_gnt, lock_timeout} !== 2'b00)
                begin n_fail++; $display("FAIL to_wait[%0d] got=%b exp=00", i, {b_gnt, lock_timeout}); end
            nxt();
        end
        #1;
        n_checks++;
        if ({b_gnt, lock_timeout} !== 2'b11)
            begin n_fail++; $display("FAIL to_release got=%b exp=11", {b_gnt, lock_timeout}); end
        nxt();
        drv_b(0, 0, 0, 0, 0);
        #1;
        n_checks++;
        if ({lock_timeout, b_rvalid, b_rdata} !== {2'b01, init_val('h40)})
            begin n_fail++; $display("FAIL to_pulse got=%h exp=%h", {lock_timeout, b_rvalid, b_rdata}, {2'b01, init_val('h40)}); end
        nxt();
    endtask

    task automatic test_timeout_disabled();
        n_a_req = 1; n_a_lock = 1;
        #1;
        n_checks++;
        if ({n_a_gnt, n_b_gnt, n_mem_en, n_mem_we, n_mem_addr} !== {4'b1010, 8'hF0})
            begin n_fail++; $display("FAIL nt_lock got=%h exp=%h", {n_a_gnt, n_b_gnt, n_mem_en, n_mem_we, n_mem_addr}, {4'b1010, 8'hF0}); end
        nxt();
        n_a_req = 0; n_a_lock = 0; n_b_req = 1;
        #1;
        n_checks++;
        if ({n_a_rvalid, n_b_rvalid, n_a_rdata, n_b_rdata, n_mem_wdata} !== {2'b10, 24'h0})
            begin n_fail++; $display("FAIL nt_rvalid got=%h exp=%h", {n_a_rvalid, n_b_rvalid, n_a_rdata, n_b_rdata, n_mem_wdata}, {2'b10, 24'h0}); end
        for (int i = 0; i < 3 * LOCK_MAX; i++) begin
            n_checks++;
            if ({n_b_gnt, n_mem_en, n_lock_timeout} !== 3'b000)
                begin n_fail++; $display("FAIL nt_wait[%0d] got=%b exp=000", i, {n_b_gnt, n_mem_en, n_lock_timeout}); end
            nxt();
            #1;
        end
        n_b_req = 0;
        nxt();
    endtask

    task automatic test_b_write_read();
        drv_b(1, 1, 0, 8'h10, 8'h05);
        #1;
        n_checks++;
        if ({b_gnt, a_gnt, mem_en, mem_we, mem_addr, mem_wdata} !== {4'b1011, 8'h10, 8'h05})
            begin n_fail++; $display("FAIL bw_write got=%h exp=%h", {b_gnt, a_gnt, mem_en, mem_we, mem_addr, mem_wdata}, {4'b1011, 8'h10, 8'h05}); end
        nxt();
        drv_b(1, 0, 0, 8'h10, 0);
        #1;
        n_checks++;
        if ({b_gnt, mem_we, b_rvalid} !== 3'b100)
            begin n_fail++; $display("FAIL bw_read got=%b exp=100", {b_gnt, mem_we, b_rvalid}); end
        nxt();
        drv_b(0, 0, 0, 0, 0);
        #1;
        n_checks++;
        if ({b_rvalid, b_rdata} !== {1'b1, 8'h05})
            begin n_fail++; $display("FAIL bw_rdata got=%h exp=%h", {b_rvalid, b_rdata}, {1'b1, 8'h05}); end
        nxt();
    endtask

    task automatic test_reset_mid_lock();
        drv_b(1, 0, 1, 8'h10, 0);
        #1;
        n_checks++;
        if ({a_gnt, b_gnt} !== 2'b01)
            begin n_fail++; $display("FAIL rml_lockb got=%b exp=01", {a_gnt, b_gnt}); end
        nxt();
        rst = 1'b1;
        drv_a(1, 0, 0, 8'hF0, 0);
        drv_b(1, 0, 0, 8'h10, 0);
        #1;
        n_checks++;
        if ({a_gnt, b_gnt, mem_en} !== 3'b000)
            begin n_fail++; $display("FAIL rml_in_reset got=%b exp=000", {a_gnt, b_gnt, mem_en}); end
        nxt();
        rst = 1'b0;
        #1;
        n_checks++;
        if ({b_rvalid, a_gnt, b_gnt} !== 3'b010)
            begin n_fail++; $display("FAIL rml_after got=%b exp=010", {b_rvalid, a_gnt, b_gnt}); end
        nxt();
        #1;
        n_checks++;
        if ({a_gnt, b_gnt, a_rvalid} !== 3'b011)
            begin n_fail++; $display("FAIL rml_next got=%b exp=011", {a_gnt, b_gnt, a_rvalid}); end
        nxt();
        drv_a(0, 0, 0, 0, 0);
        drv_b(0, 0, 0, 0, 0);
        nxt();
    endtask

    task automatic test_random();
        logic [DW-1:0] ref_mem [256];
        int            owner, last, idle;
        logic          e_rva, e_rvb, e_to, ga, gb, lck;
        logic [DW-1:0] e_rda, e_rdb;
        logic [AW+DW:0] e_bus;
        int            rate_a;

        do_reset();
        for (int i = 0; i < 256; i++) ref_mem[i] = mem[i];
        owner = -1; last = 1; idle = 0;
        e_rva = 0; e_rvb = 0; e_to = 0; e_rda = 0; e_rdb = 0;

        for (int cyc = 0; cyc < 800; cyc++) begin
            // A goes quiet in some windows so held locks have to time out
            rate_a = ((cyc / 50) % 3 == 2) ? 0 : 60;
            if (!a_req && ($urandom_range(0, 99) < rate_a))
                drv_a(1, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                      8'($urandom), 8'($urandom));
            if (!b_req && ($urandom_range(0, 99) < 50))
                drv_b(1, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                      8'($urandom), 8'($urandom));
            #1;
            ga = 0; gb = 0;
            if (owner < 0) begin
                if (a_req && b_req) begin ga = (last == 1); gb = !ga; end
                else begin ga = a_req; gb = b_req; end
            end else if (owner == 0) ga = a_req;
            else gb = b_req;

            if (ga)      e_bus = {a_we, a_addr, a_wdata};
            else if (gb) e_bus = {b_we, b_addr, b_wdata};
            else         e_bus = '0;

            n_checks++;
            if ({a_gnt, b_gnt, mem_en} !== {ga, gb, ga | gb})
                begin n_fail++; $display("FAIL rnd_grant[%0d] got=%b exp=%b", cyc, {a_gnt, b_gnt, mem_en}, {ga, gb, ga | gb}); end
            n_checks++;
            if ({mem_we, mem_addr, mem_wdata} !== e_bus)
                begin n_fail++; $display("FAIL rnd_bus[%0d] got=%h exp=%h", cyc, {mem_we, mem_addr, mem_wdata}, e_bus); end
            n_checks++;
            if ({a_rvalid, b_rvalid, lock_timeout} !== {e_rva, e_rvb, e_to})
                begin n_fail++; $display("FAIL rnd_flags[%0d] got=%b exp=%b", cyc, {a_rvalid, b_rvalid, lock_timeout}, {e_rva, e_rvb, e_to}); end
            if (e_rva) begin
                n_checks++;
                if (a_rdata !== e_rda)
                    begin n_fail++; $display("FAIL rnd_ardata[%0d] got=%h exp=%h", cyc, a_rdata, e_rda); end
            end
            if (e_rvb) begin
                n_checks++;
                if (b_rdata !== e_rdb)
                    begin n_fail++; $display("FAIL rnd_brdata[%0d] got=%h exp=%h", cyc, b_rdata, e_rdb); end
            end

            // Advance the model across the clock edge
            e_rva = ga && !a_we; e_rda = ref_mem[a_addr];
            e_rvb = gb && !b_we; e_rdb = ref_mem[b_addr];
            e_to  = 0;
            if (ga || gb) begin
                last = ga ? 0 : 1;
                if (ga && a_we) ref_mem[a_addr] = a_wdata;
                if (gb && b_we) ref_mem[b_addr] = b_wdata;
                lck   = ga ? a_lock : b_lock;
                owner = lck ? last : -1;
                idle  = 0;
            end else if (owner >= 0) begin
                idle++;
                if (LOCK_MAX != 0 && idle == LOCK_MAX) begin
                    owner = -1; idle = 0; e_to = 1;
                end
            end
            nxt();
            if (ga) drv_a(0, 0, 0, 0, 0);
            if (gb) drv_b(0, 0, 0, 0, 0);
        end
        drv_a(0, 0, 0, 0, 0);
        drv_b(0, 0, 0, 0, 0);
        nxt();
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_round_robin();
        test_lock_atomic();
        test_timeout();
        test_timeout_disabled();
        test_b_write_read();
        test_reset_mid_lock();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at time %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
